// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_wb_arbiter
// Description : Round-robin EXU/LSU writeback arbiter for the register file
//               write port, with a per-register busy scoreboard for decode.
// Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH      = 32,
    parameter int INPUT_INDEX_LEN = 5,
    parameter int INDEX_LEN       = 5,
    parameter int N_REG           = 32
) (
    input  logic                       clk,
    input  logic                       rst,

    input  logic                       exu_valid,
    output logic                       exu_ready,
    input  logic [INPUT_INDEX_LEN-1:0] exu_idx,
    input  logic [DATA_WIDTH-1:0]      exu_data,

    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [INPUT_INDEX_LEN-1:0] lsu_idx,
    input  logic [DATA_WIDTH-1:0]      lsu_data,

    input  logic                       issue_valid,
    input  logic [INPUT_INDEX_LEN-1:0] issue_idx,
    output logic                       issue_ready,

    input  logic [INPUT_INDEX_LEN-1:0] rs1_idx,
    input  logic [INPUT_INDEX_LEN-1:0] rs2_idx,
    output logic                       rs1_busy,
    output logic                       rs2_busy,
    output logic [N_REG-1:0]           busy,

    output logic                       RegWEn,
    output logic [INPUT_INDEX_LEN-1:0] RegWriteIndex,
    output logic [DATA_WIDTH-1:0]      RegWriteData
);

    localparam logic [INDEX_LEN-1:0] c_idxZero = '0;

    // Truncated indices
    logic [INDEX_LEN-1:0] w_exuIdx;
    logic [INDEX_LEN-1:0] w_lsuIdx;
    logic [INDEX_LEN-1:0] w_issueIdx;
    logic [INDEX_LEN-1:0] w_rs1Idx;
    logic [INDEX_LEN-1:0] w_rs2Idx;

    assign w_exuIdx   = exu_idx[INDEX_LEN-1:0];
    assign w_lsuIdx   = lsu_idx[INDEX_LEN-1:0];
    assign w_issueIdx = issue_idx[INDEX_LEN-1:0];
    assign w_rs1Idx   = rs1_idx[INDEX_LEN-1:0];
    assign w_rs2Idx   = rs2_idx[INDEX_LEN-1:0];

    // Round-robin pointer: 1 means LSU won the most recent grant
    logic                       r_lastGrantLsu;
    logic                       r_wen;
    logic [INPUT_INDEX_LEN-1:0] r_wIdx;
    logic [DATA_WIDTH-1:0]      r_wData;
    logic [N_REG-1:0]           r_busy;

    logic                       w_grantExu;
    logic                       w_grantLsu;
    logic                       w_grant;
    logic [INDEX_LEN-1:0]       w_winIdx;
    logic [DATA_WIDTH-1:0]      w_winData;
    logic [INPUT_INDEX_LEN-1:0] w_winIdxExt;
    logic [INPUT_INDEX_LEN-1:0] w_rs1IdxExt;
    logic [INPUT_INDEX_LEN-1:0] w_rs2IdxExt;

    assign w_grantExu = exu_valid && (!lsu_valid || r_lastGrantLsu);
    assign w_grantLsu = lsu_valid && (!exu_valid || !r_lastGrantLsu);
    assign w_grant    = w_grantExu || w_grantLsu;
    assign w_winIdx   = w_grantLsu ? w_lsuIdx  : w_exuIdx;
    assign w_winData  = w_grantLsu ? lsu_data  : exu_data;

    assign exu_ready  = w_grantExu;
    assign lsu_ready  = w_grantLsu;

    always_comb begin
        w_winIdxExt                = '0;
        w_winIdxExt[INDEX_LEN-1:0] = w_winIdx;
        w_rs1IdxExt                = '0;
        w_rs1IdxExt[INDEX_LEN-1:0] = w_rs1Idx;
        w_rs2IdxExt                = '0;
        w_rs2IdxExt[INDEX_LEN-1:0] = w_rs2Idx;
    end

    // Scoreboard next-state; a same-cycle set overrides the clear
    logic                       w_issueFire;
    logic                       w_clearFire;
    logic [N_REG-1:0]           w_setVec;
    logic [N_REG-1:0]           w_clrVec;
    logic [N_REG-1:0]           w_busyNext;

    assign issue_ready = !r_busy[w_issueIdx] || (w_issueIdx == c_idxZero);
    assign w_issueFire = issue_valid && issue_ready && (w_issueIdx != c_idxZero);
    assign w_clearFire = w_grant && (w_winIdx != c_idxZero);

    always_comb begin
        w_setVec = '0;
        w_clrVec = '0;
        if (w_issueFire) begin
            w_setVec[w_issueIdx] = 1'b1;
        end
        if (w_clearFire) begin
            w_clrVec[w_winIdx] = 1'b1;
        end
        w_busyNext    = (r_busy & ~w_clrVec) | w_setVec;
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrantLsu <= 1'b1;
            r_wen          <= 1'b0;
            r_wIdx         <= '0;
            r_wData        <= '0;
            r_busy         <= '0;
        end else begin
            r_busy <= w_busyNext;
            if (w_grant) begin
                r_lastGrantLsu <= w_grantLsu;
                r_wen          <= (w_winIdx != c_idxZero);
                r_wIdx         <= w_winIdxExt;
                r_wData        <= w_winData;
            end else begin
                r_wen <= 1'b0;
            end
        end
    end

    // The clear lands at the handshake edge, so cover the commit cycle too
    assign rs1_busy = r_busy[w_rs1Idx]
                   || (r_wen && (r_wIdx == w_rs1IdxExt) && (w_rs1Idx != c_idxZero));
    assign rs2_busy = r_busy[w_rs2Idx]
                   || (r_wen && (r_wIdx == w_rs2IdxExt) && (w_rs2Idx != c_idxZero));

    assign busy          = r_busy;
    assign RegWEn        = r_wen;
    assign RegWriteIndex = r_wIdx;
    assign RegWriteData  = r_wData;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_wb_arbiter
// Description : Directed vector bench for regfile_wb_arbiter.
// Revision    : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DW = 32;
    localparam int IW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          exu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0;
    logic [IW-1:0] exu_idx = '0, lsu_idx = '0, issue_idx = '0, rs1_idx = '0, rs2_idx = '0;
    logic [DW-1:0] exu_data = '0, lsu_data = '0;
    logic          exu_ready, lsu_ready, issue_ready, rs1_busy, rs2_busy, RegWEn;
    logic [NR-1:0] busy;
    logic [IW-1:0] RegWriteIndex;
    logic [DW-1:0] RegWriteData;

    int checks   = 0;
    int failures = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .INPUT_INDEX_LEN(IW), .INDEX_LEN(5), .N_REG(NR)
    ) dut (
        .clk(clk), .rst(rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_idx(exu_idx), .exu_data(exu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_idx(lsu_idx), .lsu_data(lsu_data),
        .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_ready(issue_ready),
        .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .busy(busy), .RegWEn(RegWEn), .RegWriteIndex(RegWriteIndex), .RegWriteData(RegWriteData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          ev; logic [IW-1:0] ei; logic [DW-1:0] ed;
        logic          lv; logic [IW-1:0] li; logic [DW-1:0] ld;
        logic          iv; logic [IW-1:0] ii;
        logic [IW-1:0] r1; logic [IW-1:0] r2;
        logic          xer; logic xlr; logic xir; logic xr1; logic xr2;
        logic          xwen; logic [IW-1:0] xwidx; logic [DW-1:0] xwd; logic [NR-1:0] xbusy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, n, act, exp);
        end
    endtask

    task automatic add(input logic ev, input int ei, input logic [DW-1:0] ed,
                       input logic lv, input int li, input logic [DW-1:0] ld,
                       input logic iv, input int ii, input int r1, input int r2,
                       input logic xer, input logic xlr, input logic xir,
                       input logic xr1, input logic xr2,
                       input logic xwen, input int xwidx, input logic [DW-1:0] xwd,
                       input logic [NR-1:0] xbusy);
        vec_t v;
        v.ev = ev; v.ei = IW'(ei); v.ed = ed;
        v.lv = lv; v.li = IW'(li); v.ld = ld;
        v.iv = iv; v.ii = IW'(ii); v.r1 = IW'(r1); v.r2 = IW'(r2);
        v.xer = xer; v.xlr = xlr; v.xir = xir; v.xr1 = xr1; v.xr2 = xr2;
        v.xwen = xwen; v.xwidx = IW'(xwidx); v.xwd = xwd; v.xbusy = xbusy;
        vecs.push_back(v);
    endtask

    initial begin
        //   ev ei ed            lv li ld       iv ii r1 r2 | er lr ir r1b r2b | wen widx wdata        busy
        add(1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 5,  32'hDEADBEEF, 32'h0);
        add(0, 0, 0,            0, 0, 0,       0, 0, 5, 0,  0, 0, 1, 1, 0,  0, 5,  32'hDEADBEEF, 32'h0);
        add(0, 0, 0,            1, 6, 32'h66,  0, 0, 5, 0,  0, 1, 1, 0, 0,  1, 6,  32'h66,       32'h0);
        add(1, 1, 32'h101,      1, 9, 32'h209, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 1,  32'h101,      32'h0);
        add(1, 2, 32'h102,      1, 9, 32'h209, 0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 9,  32'h209,      32'h0);
        add(1, 2, 32'h102,      1, 10,32'h20A, 0, 0, 0, 0,  1, 0, 1, 0, 0,  1, 2,  32'h102,      32'h0);
        add(1, 3, 32'h103,      1, 10,32'h20A, 0, 0, 0, 0,  0, 1, 1, 0, 0,  1, 10, 32'h20A,      32'h0);
        add(0, 0, 0,            0, 0, 0,       1, 7, 0, 0,  0, 0, 1, 0, 0,  0, 10, 32'h20A,      32'h80);
        add(0, 0, 0,            0, 0, 0,       1, 7, 7, 0,  0, 0, 0, 1, 0,  0, 10, 32'h20A,      32'h80);
        add(0, 0, 0,            1, 7, 32'h77,  0, 0, 7, 0,  0, 1, 1, 1, 0,  1, 7,  32'h77,       32'h0);
        add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  0, 0, 1, 1, 0,  0, 7,  32'h77,       32'h0);
        add(0, 0, 0,            0, 0, 0,       0, 0, 7, 0,  0, 0, 1, 0, 0,  0, 7,  32'h77,       32'h0);
        add(1, 3, 32'h33,       0, 0, 0,       1, 3, 0, 0,  1, 0, 1, 0, 0,  1, 3,  32'h33,       32'h08);
        add(1, 0, 32'h1234,     0, 0, 0,       1, 0, 0, 3,  1, 0, 1, 0, 1,  0, 0,  32'h1234,     32'h08);
        add(1, 3, 32'h3,        0, 0, 0,       1, 4, 0, 0,  1, 0, 1, 0, 0,  1, 3,  32'h3,        32'h10);
        add(0, 0, 0,            0, 0, 0,       1, 5, 0, 0,  0, 0, 1, 0, 0,  0, 3,  32'h3,        32'h30);
        add(0, 0, 0,            0, 0, 0,       1, 6, 0, 0,  0, 0, 1, 0, 0,  0, 3,  32'h3,        32'h70);
        add(1, 15, 32'hF00D,    0, 0, 0,       1, 7, 0, 0,  1, 0, 1, 0, 0,  1, 15, 32'hF00D,     32'hF0);

        #1 rst = 1'b1;
        #2 chk("async_reset_wen", -1, 64'(RegWEn), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_wen",   -1, 64'(RegWEn), 64'd0);
        chk("reset_busy",  -1, 64'(busy), 64'd0);
        chk("reset_widx",  -1, 64'(RegWriteIndex), 64'd0);
        chk("reset_wdata", -1, 64'(RegWriteData), 64'd0);

        for (int n = 0; n < vecs.size(); n++) begin
            if (n != 0) @(negedge clk);
            exu_valid = vecs[n].ev; exu_idx = vecs[n].ei; exu_data = vecs[n].ed;
            lsu_valid = vecs[n].lv; lsu_idx = vecs[n].li; lsu_data = vecs[n].ld;
            issue_valid = vecs[n].iv; issue_idx = vecs[n].ii;
            rs1_idx = vecs[n].r1; rs2_idx = vecs[n].r2;
            #1;
            chk("exu_ready",   n, 64'(exu_ready),   64'(vecs[n].xer));
            chk("lsu_ready",   n, 64'(lsu_ready),   64'(vecs[n].xlr));
            chk("issue_ready", n, 64'(issue_ready), 64'(vecs[n].xir));
            chk("rs1_busy",    n, 64'(rs1_busy),    64'(vecs[n].xr1));
            chk("rs2_busy",    n, 64'(rs2_busy),    64'(vecs[n].xr2));
            @(posedge clk);
            #1;
            chk("RegWEn",        n, 64'(RegWEn),        64'(vecs[n].xwen));
            chk("RegWriteIndex", n, 64'(RegWriteIndex), 64'(vecs[n].xwidx));
            chk("RegWriteData",  n, 64'(RegWriteData),  64'(vecs[n].xwd));
            chk("busy",          n, 64'(busy),          64'(vecs[n].xbusy));
        end

        // Asynchronous reset mid-cycle while a write is in flight
        exu_valid = 1'b0; issue_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("midrst_wen",   -1, 64'(RegWEn), 64'd0);
        chk("midrst_busy",  -1, 64'(busy), 64'd0);
        chk("midrst_wdata", -1, 64'(RegWriteData), 64'd0);
        chk("midrst_widx",  -1, 64'(RegWriteIndex), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        exu_valid = 1'b1; exu_idx = 5'd1; exu_data = 32'hAAAA;
        lsu_valid = 1'b1; lsu_idx = 5'd2; lsu_data = 32'hBBBB;
        #1;
        chk("post_rst_exu_ready", -1, 64'(exu_ready), 64'd1);
        chk("post_rst_lsu_ready", -1, 64'(lsu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("post_rst_widx", -1, 64'(RegWriteIndex), 64'd1);
        chk("post_rst_wen",  -1, 64'(RegWEn), 64'd1);
        @(negedge clk);
        exu_idx = 5'd3;
        #1;
        chk("post_rst_second_lsu", -1, 64'(lsu_ready), 64'd1);
        @(negedge clk);
        exu_valid = 1'b0; lsu_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
